// File: rtl/med_reminder_pkg.sv
// Shared definitions for the medication-reminder scheduler.
// Provides the minute-of-day constants, the alert FSM state type and the
// width helper for one packed schedule entry {valid, ch, minute}.
package med_reminder_pkg;

  localparam int MIN_PER_DAY = 1440;
  localparam int MIN_W       = 11;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ALERT  = 2'd1,
    SNOOZE = 2'd2
  } state_t;

  // Width of a packed schedule entry {valid, ch[ch_w-1:0], minute[MIN_W-1:0]}.
  function automatic int entry_w(input int ch_w);
    return 1 + ch_w + MIN_W;
  endfunction

endpackage

// File: rtl/med_time_base.sv
// Minute tick prescaler and minute-of-day counter.
// Ports:
//   clk, rst_n   - clock, asynchronous active-low reset
//   ena          - when low the prescaler and minute counter hold
//   load         - load load_min into the minute counter, clear prescaler
//   load_min     - minute to load (>= 1440 loads 0)
//   tick         - one-cycle pulse on the prescaler wrap (never during load)
//   now_min      - current minute of day, 0..1439
module med_time_base
  import med_reminder_pkg::*;
#(
  parameter int TICK_DIV = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ena,
  input  logic             load,
  input  logic [MIN_W-1:0] load_min,
  output logic             tick,
  output logic [MIN_W-1:0] now_min
);

  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  logic [PW-1:0]    presc_reg;
  logic [MIN_W-1:0] now_reg;

  // A load takes priority and suppresses the tick of the same cycle.
  assign tick    = ena && !load && (presc_reg == PW'(TICK_DIV - 1));
  assign now_min = now_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presc_reg <= '0;
      now_reg   <= '0;
    end else if (load) begin
      presc_reg <= '0;
      now_reg   <= (load_min >= MIN_W'(MIN_PER_DAY)) ? '0 : load_min;
    end else if (ena) begin
      if (tick) begin
        presc_reg <= '0;
        now_reg   <= (now_reg == MIN_W'(MIN_PER_DAY - 1)) ? '0 : now_reg + 1'b1;
      end else begin
        presc_reg <= presc_reg + 1'b1;
      end
    end
  end

endmodule

// File: rtl/med_reminder_sched.sv
// Multi-channel medication reminder scheduling core.
// Optional feature: define MED_MISSED_LOG_EN to build per-channel 8-bit
// saturating missed-dose counters; otherwise missed_cnt is tied to 0.
// Ports:
//   clk, rst_n          - clock, asynchronous active-low reset
//   ena                 - low holds prescaler, scan and FSM (config still written)
//   cfg_we/addr/wdata   - schedule entry write {valid, ch, minute}
//   time_we/time_wdata  - load minute of day (aborts a running scan)
//   ack, snooze         - user dose-taken / snooze inputs
//   rd_ch               - channel selected onto missed_cnt
//   now_min             - current minute of day
//   alarm, alarm_ch     - alert active and its channel
//   snoozed             - alert is snoozed
//   pending             - channels due and not yet resolved
//   missed_cnt          - missed-dose count of rd_ch (combinational)
module med_reminder_sched
  import med_reminder_pkg::*;
#(
  parameter int NUM_CH         = 4,
  parameter int MEM_DEPTH      = 16,
  parameter int MEM_ADDR_WIDTH = 4,
  parameter int TICK_DIV       = 32,
  parameter int SNOOZE_MIN     = 5,
  parameter int TIMEOUT_MIN    = 30,
  localparam int CH_W          = (NUM_CH > 1) ? $clog2(NUM_CH) : 1,
  localparam int EW            = entry_w(CH_W)
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      ena,
  input  logic                      cfg_we,
  input  logic [MEM_ADDR_WIDTH-1:0] cfg_addr,
  input  logic [EW-1:0]             cfg_wdata,
  input  logic                      time_we,
  input  logic [MIN_W-1:0]          time_wdata,
  input  logic                      ack,
  input  logic                      snooze,
  input  logic [CH_W-1:0]           rd_ch,
  output logic [MIN_W-1:0]          now_min,
  output logic                      alarm,
  output logic [CH_W-1:0]           alarm_ch,
  output logic                      snoozed,
  output logic [NUM_CH-1:0]         pending,
  output logic [7:0]                missed_cnt
);

  localparam int SW = $clog2(SNOOZE_MIN + 1);
  localparam int TW = $clog2(TIMEOUT_MIN + 1);
  localparam logic [MEM_ADDR_WIDTH:0]   DEPTH_C = (MEM_ADDR_WIDTH + 1)'(MEM_DEPTH);
  localparam logic [MEM_ADDR_WIDTH-1:0] LAST_IDX = MEM_ADDR_WIDTH'(MEM_DEPTH - 1);

  logic tick;

  med_time_base #(.TICK_DIV(TICK_DIV)) u_time_base (
    .clk      (clk),
    .rst_n    (rst_n),
    .ena      (ena),
    .load     (time_we),
    .load_min (time_wdata),
    .tick     (tick),
    .now_min  (now_min)
  );

  // ---------------- schedule memory ----------------
  // Valid bits need a reset, so they live in a flop vector; the payload
  // fields sit in plain arrays without reset.
  logic [MEM_DEPTH-1:0] valid_reg;
  logic [CH_W-1:0]      ch_mem  [MEM_DEPTH];
  logic [MIN_W-1:0]     min_mem [MEM_DEPTH];

  logic cfg_ok;
  assign cfg_ok = cfg_we && ({1'b0, cfg_addr} < DEPTH_C);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) valid_reg <= '0;
    else if (cfg_ok) valid_reg[cfg_addr] <= cfg_wdata[EW-1];
  end

  always_ff @(posedge clk) begin
    if (cfg_ok) begin
      ch_mem[cfg_addr]  <= cfg_wdata[MIN_W +: CH_W];
      min_mem[cfg_addr] <= cfg_wdata[MIN_W-1:0];
    end
  end

  // ---------------- scanner ----------------
  // The compare reads the array asynchronously, so a write landing in the
  // compare cycle only takes effect at the edge: the scan sees old contents.
  logic                      scan_active_reg;
  logic [MEM_ADDR_WIDTH-1:0] scan_idx_reg;
  logic                      scan_hit;
  logic [CH_W-1:0]           scan_ch;
  logic [NUM_CH-1:0]         set_vec;
  logic [NUM_CH-1:0]         clr_vec;
  logic                      clr_en;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      scan_active_reg <= 1'b0;
      scan_idx_reg    <= '0;
    end else if (time_we) begin
      scan_active_reg <= 1'b0;
    end else if (tick) begin
      scan_active_reg <= 1'b1;
      scan_idx_reg    <= '0;
    end else if (scan_active_reg && ena) begin
      if (scan_idx_reg == LAST_IDX) scan_active_reg <= 1'b0;
      else scan_idx_reg <= scan_idx_reg + 1'b1;
    end
  end

  assign scan_ch  = ch_mem[scan_idx_reg];
  assign scan_hit = scan_active_reg && ena && !time_we && valid_reg[scan_idx_reg]
                    && (min_mem[scan_idx_reg] == now_min);

  // ---------------- alert FSM ----------------
  state_t            state_reg, state_next;
  logic [CH_W-1:0]   alarm_ch_reg, alarm_ch_next;
  logic [SW-1:0]     snz_reg, snz_next;
  logic [TW-1:0]     to_reg, to_next;
  logic [NUM_CH-1:0] pending_reg;
  logic              alarm_reg, snoozed_reg;
  logic              miss;
  logic [CH_W-1:0]   low_ch;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_CH; gi++) begin : g_ch
      assign set_vec[gi] = scan_hit && (scan_ch == CH_W'(gi));
      assign clr_vec[gi] = clr_en && (alarm_ch_reg == CH_W'(gi));
    end
  endgenerate

  always_comb begin
    low_ch = '0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (pending_reg[i]) low_ch = CH_W'(i);
    end
  end

  always_comb begin
    state_next    = state_reg;
    alarm_ch_next = alarm_ch_reg;
    snz_next      = snz_reg;
    to_next       = to_reg;
    clr_en        = 1'b0;
    miss          = 1'b0;
    if (ena) begin
      case (state_reg)
        IDLE: begin
          if (|pending_reg) begin
            state_next    = ALERT;
            alarm_ch_next = low_ch;
            to_next       = '0;
          end
        end
        ALERT, SNOOZE: begin
          if (tick) to_next = to_reg + 1'b1;
          // Priority: ack, then timeout, then snooze request / snooze expiry.
          if (ack) begin
            clr_en     = 1'b1;
            state_next = IDLE;
          end else if (tick && (to_reg == TW'(TIMEOUT_MIN - 1))) begin
            clr_en     = 1'b1;
            miss       = 1'b1;
            state_next = IDLE;
          end else if (state_reg == ALERT) begin
            if (snooze) begin
              state_next = SNOOZE;
              snz_next   = SW'(SNOOZE_MIN);
            end
          end else if (tick) begin
            snz_next = snz_reg - 1'b1;
            if (snz_reg == SW'(1)) state_next = ALERT;
          end
        end
        default: state_next = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg    <= IDLE;
      alarm_ch_reg <= '0;
      snz_reg      <= '0;
      to_reg       <= '0;
      pending_reg  <= '0;
      alarm_reg    <= 1'b0;
      snoozed_reg  <= 1'b0;
    end else begin
      state_reg    <= state_next;
      alarm_ch_reg <= alarm_ch_next;
      snz_reg      <= snz_next;
      to_reg       <= to_next;
      // A clear wins over a same-cycle match: that match is absorbed.
      pending_reg  <= (pending_reg | set_vec) & ~clr_vec;
      alarm_reg    <= (state_next == ALERT);
      snoozed_reg  <= (state_next == SNOOZE);
    end
  end

  assign alarm    = alarm_reg;
  assign alarm_ch = alarm_ch_reg;
  assign snoozed  = snoozed_reg;
  assign pending  = pending_reg;

  // ---------------- missed-dose log ----------------
`ifdef MED_MISSED_LOG_EN
  logic [7:0] missed_reg [NUM_CH];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_CH; i++) missed_reg[i] <= '0;
    end else if (miss) begin
      for (int i = 0; i < NUM_CH; i++) begin
        if ((alarm_ch_reg == CH_W'(i)) && (missed_reg[i] != 8'hFF))
          missed_reg[i] <= missed_reg[i] + 1'b1;
      end
    end
  end

  always_comb begin
    missed_cnt = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (rd_ch == CH_W'(i)) missed_cnt = missed_reg[i];
    end
  end
`else
  logic unused_log;
  assign unused_log = ^{rd_ch, miss};
  assign missed_cnt = '0;
`endif

endmodule
